rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//   Boot-time reader for the combinational program ROM. Steps the ROM byte
//   address from 0 until the ROM raises done. Packs bytes little-endian into
//   32-bit words and writes each word to main memory over a ready-handshaked
//   write port. The CPU is held off, via busy, until the load has finished.
// PARAMETERS
//   LOAD_BASE   32'h0000_0000  memory byte address of ROM byte 0 (word-aligned)
//   MAX_BYTES   32'd65536      safety limit on bytes read if ROM done never asserts
// PORTS
//   clock          in   1   system clock; all state changes on posedge
//   reset          in   1   synchronous, active-high
//   start          in   1   level/pulse; begins a load when sampled in IDLE or DONE
//   rom_address    out  32  byte address to ROM (registered)
//   rom_byte       in   8   ROM data for rom_address; combinational, valid same cycle
//   rom_done       in   1   high when rom_address is the last ROM byte
//   mem_write      out  1   write request, held until accepted
//   mem_address    out  32  word-aligned byte address of the write
//   mem_data       out  32  write data; byte k = ROM byte (word_base + k)
//   mem_ready      in   1   memory accepts the write on a cycle where mem_write=1
//   busy           out  1   high from start acceptance until final write accepted
//   finished       out  1   high in DONE; cleared when a new load starts
//   error          out  1   MAX_BYTES reached without rom_done; sticky until next start
// BEHAVIOUR
//   Reset: state=IDLE; rom_address, mem_address, mem_data, word buffer, byte count = 0;
//     mem_write, busy, finished, error = 0. Reset mid-load aborts immediately.
//     No write is completed after the reset edge.
//   States: IDLE, FETCH, WRITE, DONE.
//   IDLE/DONE + start: rom_address=0, buffer=0, count=0, busy=1, finished=0, error=0 -> FETCH.
//   FETCH (one byte per clock): buffer lane rom_address[1:0] <= rom_byte; count+=1.
//     - Go to WRITE if rom_done, or lane==3, or count+1==MAX_BYTES.
//       Load mem_data=buffer incl. this byte (unfilled lanes 0), mem_address=
//       LOAD_BASE+{rom_address[31:2],2'b00}, mem_write=1, last=(rom_done|limit),
//       err_pending=(limit & ~rom_done).
//     - Otherwise rom_address+=1 and stay in FETCH.
//   WRITE: mem_write, mem_address, mem_data, rom_address held stable while mem_ready=0.
//     - On the clock with mem_ready=1: mem_write<=0. If last: -> DONE, busy=0,
//       finished=1, error=err_pending. Otherwise rom_address+=1, buffer=0, -> FETCH.
//   DONE: outputs hold; start re-runs the full load.
//   start while busy (FETCH/WRITE) is ignored.
//   rom_done is sampled only in FETCH. Each completed word costs 4 FETCH + >=1 WRITE clocks.
//   Address arithmetic is 32-bit, modulo 2^32. LOAD_BASE[1:0] must be 0.
//   Partial final word (rom_done at lane<3) is written once, upper lanes zero.
// TESTING
//   1 ROM image 14,20,57,0,0,0,1,0,0,0,5,1,0..., rom_done at 27, mem_ready=1, LOAD_BASE=0
//     -> 7 writes: @0=0x0039140E, @4=0x00010000, @8=0x01050000, @12..@24=0.
//     -> finished=1 exactly 35 clocks after the start-sampling edge.
//   2 rom_done at address 5, bytes 0xAA,0xBB,0xCC,0xDD,0x11,0x22
//     -> 2 writes: @0=0xDDCCBBAA, @4=0x00002211; error=0.
//   3 mem_ready low for 3 clocks on first write -> mem_write, mem_address, mem_data
//     and rom_address stable all 3 clocks; exactly one write recorded per word.
//   4 rom_done tied 0, MAX_BYTES=8 -> 2 writes (@0, @4), then DONE with finished=1, error=1.
//   5 reset pulsed during the FETCH of byte 6 -> next clock all outputs at reset
//     values, no further mem_write; new start reloads from address 0 correctly.
//   6 start held high throughout the load -> no restart mid-load.
//     After DONE, start immediately restarts and finished drops.

Source files
------------

// File: rtl/rom_loader.sv
// Boot loader: walks the combinational program ROM from byte 0, packs bytes
// little-endian into 32-bit words and writes each word to main memory.
module rom_loader #(
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter logic [31:0] MAX_BYTES = 32'd65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic        busy,
  output logic        finished,
  output logic        error,
  output logic [1:0]  dbg_state
);

  // Write handshake: a word transfers on the rising edge where mem_write and
  // mem_ready are both high; until then address and data are held stable.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state,       w_state;
  logic [31:0] r_rom_address, w_rom_address;
  logic [31:0] r_mem_address, w_mem_address;
  logic [31:0] r_mem_data,    w_mem_data;
  logic [31:0] r_buffer,      w_buffer;
  logic [31:0] r_count,       w_count;
  logic        r_mem_write,   w_mem_write;
  logic        r_busy,        w_busy;
  logic        r_finished,    w_finished;
  logic        r_error,       w_error;
  logic        r_last,        w_last;
  logic        r_err_pending, w_err_pending;

  logic [1:0]  w_lane;
  logic [31:0] w_fill;
  logic        w_limit;

  always_comb begin
    w_state       = r_state;
    w_rom_address = r_rom_address;
    w_mem_address = r_mem_address;
    w_mem_data    = r_mem_data;
    w_buffer      = r_buffer;
    w_count       = r_count;
    w_mem_write   = r_mem_write;
    w_busy        = r_busy;
    w_finished    = r_finished;
    w_error       = r_error;
    w_last        = r_last;
    w_err_pending = r_err_pending;

    w_lane  = r_rom_address[1:0];
    w_fill  = r_buffer;
    w_fill[{w_lane, 3'b000} +: 8] = rom_byte;
    w_limit = ((r_count + 32'd1) == MAX_BYTES);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_rom_address = 32'd0;
          w_buffer      = 32'd0;
          w_count       = 32'd0;
          w_busy        = 1'b1;
          w_finished    = 1'b0;
          w_error       = 1'b0;
          w_state       = S_FETCH;
        end
      end
      S_FETCH: begin
        w_buffer = w_fill;
        w_count  = r_count + 32'd1;
        if (rom_done || (w_lane == 2'd3) || w_limit) begin
          w_mem_data    = w_fill;
          w_mem_address = LOAD_BASE + {r_rom_address[31:2], 2'b00};
          w_mem_write   = 1'b1;
          w_last        = rom_done | w_limit;
          w_err_pending = w_limit & ~rom_done;
          w_state       = S_WRITE;
        end else begin
          w_rom_address = r_rom_address + 32'd1;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          w_mem_write = 1'b0;
          if (r_last) begin
            w_busy     = 1'b0;
            w_finished = 1'b1;
            w_error    = r_err_pending;
            w_state    = S_DONE;
          end else begin
            w_rom_address = r_rom_address + 32'd1;
            w_buffer      = 32'd0;
            w_state       = S_FETCH;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rom_address <= 32'd0;
      r_mem_address <= 32'd0;
      r_mem_data    <= 32'd0;
      r_buffer      <= 32'd0;
      r_count       <= 32'd0;
      r_mem_write   <= 1'b0;
      r_busy        <= 1'b0;
      r_finished    <= 1'b0;
      r_error       <= 1'b0;
      r_last        <= 1'b0;
      r_err_pending <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rom_address <= w_rom_address;
      r_mem_address <= w_mem_address;
      r_mem_data    <= w_mem_data;
      r_buffer      <= w_buffer;
      r_count       <= w_count;
      r_mem_write   <= w_mem_write;
      r_busy        <= w_busy;
      r_finished    <= w_finished;
      r_error       <= w_error;
      r_last        <= w_last;
      r_err_pending <= w_err_pending;
    end
  end

  assign rom_address = r_rom_address;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_write   = r_mem_write;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign error       = r_error;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: ROM model, write scoreboard, directed load scenarios.
module tb_rom_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        rom_done;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        busy;
  logic        finished;
  logic        error;
  logic [1:0]  dbg_state;

  logic        start2;
  logic [31:0] rom_address2;
  logic [7:0]  rom_byte2;
  logic        mem_write2;
  logic [31:0] mem_address2;
  logic [31:0] mem_data2;
  logic        busy2;
  logic        finished2;
  logic        error2;
  logic [1:0]  dbg_state2;

  logic [7:0]  img  [64];
  logic [7:0]  img2 [64];
  logic [31:0] rom_last;

  logic [63:0] exp_q[$];
  logic [63:0] exp2_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_wr2 = 0;

  rom_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .finished(finished), .error(error),
    .dbg_state(dbg_state)
  );

  rom_loader #(.LOAD_BASE(32'h0000_1000), .MAX_BYTES(32'd8)) dut_lim (
    .clock(clock), .reset(reset), .start(start2),
    .rom_address(rom_address2), .rom_byte(rom_byte2), .rom_done(1'b0),
    .mem_write(mem_write2), .mem_address(mem_address2), .mem_data(mem_data2),
    .mem_ready(1'b1), .busy(busy2), .finished(finished2), .error(error2),
    .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // combinational ROM models
  assign rom_byte  = (rom_address < 32'd64) ? img[rom_address[5:0]] : 8'h00;
  assign rom_done  = (rom_address == rom_last);
  assign rom_byte2 = (rom_address2 < 32'd64) ? img2[rom_address2[5:0]] : 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboards: a write is accepted on the coming edge when both are high
  always @(negedge clock) begin
    if (!reset && mem_write && mem_ready) begin
      n_wr++;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_addr_data", {mem_address, mem_data}, exp_q.pop_front());
    end
    if (!reset && mem_write2) begin
      n_wr2++;
      check("lim_write_expected", 64'(exp2_q.size() != 0), 64'd1);
      if (exp2_q.size() != 0) check("lim_write_addr_data", {mem_address2, mem_data2}, exp2_q.pop_front());
    end
  end

  task automatic load_image1();
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    img[0] = 8'd14; img[1] = 8'd20; img[2] = 8'd57;
    img[6] = 8'd1;  img[10] = 8'd5; img[11] = 8'd1;
    rom_last = 32'd27;
  endtask

  task automatic push_image1();
    exp_q.push_back({32'd0,  32'h0039140E});
    exp_q.push_back({32'd4,  32'h00010000});
    exp_q.push_back({32'd8,  32'h01050000});
    for (int a = 12; a <= 24; a += 4) exp_q.push_back({32'(a), 32'h0});
  endtask

  task automatic load_image2();
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    img[3] = 8'hDD; img[4] = 8'h11; img[5] = 8'h22;
    rom_last = 32'd5;
  endtask

  task automatic push_image2();
    exp_q.push_back({32'd0, 32'hDDCCBBAA});
    exp_q.push_back({32'd4, 32'h00002211});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_finish(input string tag, output int n);
    n = 0;
    while (!finished && n < 500) begin
      tick();
      n++;
    end
    check(tag, 64'(finished), 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 64; i++) img2[i] = 8'(i + 1);
    load_image1();
    tick(); tick();
    reset = 1'b0;

    check("rst_rom_address", 64'(rom_address), 64'd0);
    check("rst_mem_write",   64'(mem_write), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_data",    64'(mem_data), 64'd0);
    check("rst_flags",       64'({busy, finished, error}), 64'd0);
    check("rst_state",       64'(dbg_state), 64'd0);

    // 1: reference image, latency from the start-sampling edge
    load_image1(); push_image1(); n_wr = 0;
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    run_to_finish("t1_finish_timeout", n);
    check("t1_latency", 64'(n), 64'd35);
    check("t1_writes", 64'(n_wr), 64'd7);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_busy_done", 64'({busy, error}), 64'd0);

    // 2: partial final word
    load_image2(); push_image2(); n_wr = 0;
    pulse_start();
    check("t2_finished_cleared", 64'(finished), 64'd0);
    run_to_finish("t2_finish_timeout", n);
    check("t2_writes", 64'(n_wr), 64'd2);
    check("t2_error", 64'(error), 64'd0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // 3: back-pressure on the first write
    load_image2(); push_image2(); n_wr = 0;
    mem_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!mem_write && n < 20) begin tick(); n++; end
    check("t3_write_timeout", 64'(mem_write), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_write", 64'(mem_write), 64'd1);
      check("t3_hold_addr",  64'(mem_address), 64'd0);
      check("t3_hold_data",  64'(mem_data), 64'hDDCCBBAA);
      check("t3_hold_rom",   64'(rom_address), 64'd3);
      tick();
    end
    mem_ready = 1'b1;
    run_to_finish("t3_finish_timeout", n);
    check("t3_writes", 64'(n_wr), 64'd2);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: no rom_done, byte limit of 8 on the second instance
    exp2_q.push_back({32'h1000, 32'h04030201});
    exp2_q.push_back({32'h1004, 32'h08070605});
    n_wr2 = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (!finished2 && n < 100) begin tick(); n++; end
    check("t4_finished", 64'(finished2), 64'd1);
    check("t4_error", 64'(error2), 64'd1);
    check("t4_writes", 64'(n_wr2), 64'd2);
    exp2_q.push_back({32'h1000, 32'h04030201});
    exp2_q.push_back({32'h1004, 32'h08070605});
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("t4_restart_clears", 64'({busy2, finished2, error2}), 64'b100);
    n = 0;
    while (!finished2 && n < 100) begin tick(); n++; end
    check("t4_rerun_error", 64'({finished2, error2}), 64'b11);
    check("t4_queue_empty", 64'(exp2_q.size()), 64'd0);

    // 5: reset during FETCH of byte 6
    load_image1(); n_wr = 0;
    exp_q.push_back({32'd0, 32'h0039140E});
    pulse_start();
    n = 0;
    while (rom_address != 32'd6 && n < 50) begin tick(); n++; end
    check("t5_reach_byte6", 64'(rom_address), 64'd6);
    check("t5_in_fetch", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_rom_address", 64'(rom_address), 64'd0);
    check("t5_rst_mem", 64'({mem_write, mem_address, mem_data}), 64'd0);
    check("t5_rst_flags", 64'({busy, finished, error}), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("t5_quiet", 64'(mem_write), 64'd0);
    check("t5_writes_before_reset", 64'(n_wr), 64'd1);
    push_image1(); n_wr = 0;
    pulse_start();
    run_to_finish("t5_finish_timeout", n);
    check("t5_reload_writes", 64'(n_wr), 64'd7);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: start held high through the whole load
    push_image1(); n_wr = 0;
    start = 1'b1;
    tick();
    run_to_finish("t6_finish_timeout", n);
    check("t6_no_restart", 64'(n), 64'd35);
    check("t6_writes", 64'(n_wr), 64'd7);
    push_image1();
    tick();
    start = 1'b0;
    check("t6_restart", 64'({busy, finished}), 64'b10);
    run_to_finish("t6_rerun_timeout", n);
    check("t6_total_writes", 64'(n_wr), 64'd14);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
